// File: rtl/hilo_acc_if.sv
// Product and direct-write channel between the multiplier/issue side and the HI/LO accumulator.
interface hilo_acc_if #(
  parameter int W = 32
);
  logic           mul_valid;
  logic [2*W-1:0] mul_z;
  logic [1:0]     mul_op;
  logic           mt_valid;
  logic           mt_sel;
  logic [W-1:0]   mt_data;
  logic           mt_ready;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           hi_pending;
  logic           ov;

  modport master (
    output mul_valid, mul_z, mul_op, mt_valid, mt_sel, mt_data,
    input  mt_ready, hi, lo, hi_pending, ov
  );

  modport slave (
    input  mul_valid, mul_z, mul_op, mt_valid, mt_sel, mt_data,
    output mt_ready, hi, lo, hi_pending, ov
  );
endinterface

// File: rtl/hilo_acc.sv
// HI/LO register pair with write/accumulate/subtract of a 2W-bit product, split into a
// LO-half stage and a HI-half stage joined by a registered carry/borrow.
module hilo_acc_chk (
  input logic clk,
  input logic reset,
  input logic mul_valid,
  input logic mt_ready,
  input logic hi_pending
);
  a_pend_follows_mul: assert property (@(posedge clk) disable iff (!reset)
    mul_valid |=> hi_pending);
  a_mt_exclusive: assert property (@(posedge clk) disable iff (!reset)
    mt_ready |-> (!mul_valid && !hi_pending));
endmodule

module hilo_acc #(
  parameter int W = 32
) (
  input logic       clk,
  input logic       reset,
  hilo_acc_if.slave bus
);
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_ACC   = 2'b01,
    OP_SUB   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] zh_q, zh_d;
  logic         c_q, c_d;
  logic         s2_valid_q, s2_valid_d;
  logic         ov_q, ov_d;
  op_e          op_q, op_d;

  logic [W-1:0] zl_s;
  logic [W:0]   lo_sum_s, lo_dif_s, hi_sum_s, hi_dif_s;
  logic         mt_ready_s;
  op_e          mul_op_s;

  assign zl_s     = bus.mul_z[W-1:0];
  assign mul_op_s = op_e'(bus.mul_op);

  // Top bit of each W+1-bit result is the carry (sum) or borrow (difference).
  assign lo_sum_s = {1'b0, lo_q} + {1'b0, zl_s};
  assign lo_dif_s = {1'b0, lo_q} - {1'b0, zl_s};
  assign hi_sum_s = {1'b0, hi_q} + {1'b0, zh_q} + {{W{1'b0}}, c_q};
  assign hi_dif_s = {1'b0, hi_q} - {1'b0, zh_q} - {{W{1'b0}}, c_q};

  assign mt_ready_s = bus.mt_valid & ~bus.mul_valid & ~s2_valid_q;

  // Next-state for both pipeline stages and the direct-write path.
  always_comb begin
    lo_d       = lo_q;
    hi_d       = hi_q;
    zh_d       = zh_q;
    c_d        = c_q;
    op_d       = op_q;
    ov_d       = ov_q;
    s2_valid_d = bus.mul_valid;

    if (bus.mul_valid) begin
      zh_d = bus.mul_z[2*W-1:W];
      op_d = mul_op_s;
      case (mul_op_s)
        OP_ACC:  {c_d, lo_d} = lo_sum_s;
        OP_SUB:  {c_d, lo_d} = lo_dif_s;
        default: begin
          lo_d = zl_s;
          c_d  = 1'b0;
        end
      endcase
    end else begin
      c_d = c_q;
    end

    // Stage 2 runs alongside a new stage 1; it only touches HI and ov.
    if (s2_valid_q) begin
      case (op_q)
        OP_ACC: begin
          hi_d = hi_sum_s[W-1:0];
          if (hi_sum_s[W]) begin
            ov_d = 1'b1;
          end else begin
            ov_d = ov_q;
          end
        end
        OP_SUB: begin
          hi_d = hi_dif_s[W-1:0];
          if (hi_dif_s[W]) begin
            ov_d = 1'b1;
          end else begin
            ov_d = ov_q;
          end
        end
        default: begin
          hi_d = zh_q;
          ov_d = 1'b0;
        end
      endcase
    end else begin
      hi_d = hi_q;
    end

    // Direct write can never coincide with either stage, so it cannot collide above.
    if (mt_ready_s) begin
      ov_d = 1'b0;
      if (bus.mt_sel) begin
        hi_d = bus.mt_data;
      end else begin
        lo_d = bus.mt_data;
      end
    end else begin
      ov_d = ov_d;
    end
  end

  // State registers; reset drops any in-flight HI half.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q       <= {W{1'b0}};
      hi_q       <= {W{1'b0}};
      zh_q       <= {W{1'b0}};
      c_q        <= 1'b0;
      op_q       <= OP_WRITE;
      ov_q       <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      zh_q       <= zh_d;
      c_q        <= c_d;
      op_q       <= op_d;
      ov_q       <= ov_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign bus.lo         = lo_q;
  assign bus.hi         = hi_q;
  assign bus.ov         = ov_q;
  assign bus.hi_pending = s2_valid_q;
  assign bus.mt_ready   = mt_ready_s;

  hilo_acc_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .mul_valid  (bus.mul_valid),
    .mt_ready   (mt_ready_s),
    .hi_pending (s2_valid_q)
  );
endmodule

// File: doc/hilo_acc.md
Name: hilo_acc

Overview:
- Downstream consumer of the 64-bit unsigned product from the multiplier.
- Holds the architectural HI/LO register pair and supports three product operations: write, accumulate (MADDU-style) and subtract (MSUBU-style).
- Also supports direct MTHI/MTLO writes.
- Splits the 64-bit add/sub into a two-stage 32-bit pipeline (LO half, then HI half with registered carry), so back-to-back products are accepted every cycle.

Parameters:
- W, 32, half-width; product is 2*W bits, HI and LO are W bits each.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- mul_valid  in  1  product present on mul_z this cycle; always accepted.
- mul_z  in  2W  unsigned product from the multiplier (z).
- mul_op  in  2  00 = write, 01 = accumulate, 10 = subtract, 11 = reserved (treated as write).
- mt_valid  in  1  direct-write request.
- mt_sel  in  1  0 = LO, 1 = HI.
- mt_data  in  W  direct-write data.
- mt_ready  out  1  direct write accepted this cycle.
- hi  out  W  HI register.
- lo  out  W  LO register.
- hi_pending  out  1  HI update in flight; consumers stall MFHI while 1.
- ov  out  1  sticky wrap flag for accumulate/subtract.

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, s2_valid=0, carry=0, ov=0, any stage-2 op discarded. Outputs follow immediately, without waiting for a clock edge.
- Stage 1, edge E where mul_valid=1, on the LO half:
  - write: lo <= z[W-1:0], c <= 0.
  - accumulate: {c, lo} <= lo + z[W-1:0].
  - subtract: {c, lo} <= lo - z[W-1:0], with c = borrow.
  - Also latched into stage-2 registers: z[2W-1:W] and op; s2_valid <= 1.
- Stage 2, edge E+1 if s2_valid, on the HI half:
  - write: hi <= zh.
  - accumulate: {co, hi} <= hi + zh + c.
  - subtract: {bo, hi} <= hi - zh - c.
  - s2_valid <= 0 unless a new product was accepted at E+1.
- Latency: LO visible after E, HI visible after E+1.
- hi_pending = s2_valid (combinational from register).
- Back-to-back: a product at E+1 uses the LO written at E in its stage 1, and its stage 2 at E+2 uses the HI written at E+1. The result is exactly the sequential 64-bit result with no bubbles.
- Arithmetic is modulo 2^(2W).
- ov:
  - Set at stage 2 on co=1 (accumulate) or bo=1 (subtract).
  - Cleared at stage 2 of a write op, or on any accepted mt write.
  - A set and a clear in the same cycle cannot occur.
- Direct write:
  - mt_ready = mt_valid & ~mul_valid & ~s2_valid.
  - When accepted: at the edge, the selected register <= mt_data and ov <= 0; the other register is unchanged.
  - While mt_ready=0 the requester holds mt_valid and mt_data.
  - Priority: mul_valid beats mt_valid; a pending stage 2 beats mt_valid.
- mul_op=11 behaves exactly as 00.
- No internal ready for products: the block never stalls the multiplier.

Test Plan:
- Reset 0→1, mul_valid at E with z=100 (10*10), op=write → lo=100 after E, hi_pending=1 during E..E+1, hi=0 after E+1, ov=0.
- lo=100, hi=0; accumulate z=400 (20*20) at E, then z=10000 (100*100) at E+1 → lo=500 after E, lo=10500 after E+1, hi=0, hi_pending high for 2 cycles.
- hi=0, lo=0xFFFFFFFF; accumulate z=1 → lo=0 after E, hi=1 after E+1, ov=0. Then hi=lo=0xFFFFFFFF, accumulate z=1 → hi=lo=0, ov=1.
- hi=lo=0; subtract z=1 → lo=0xFFFFFFFF after E, hi=0xFFFFFFFF after E+1, ov=1. Then mt_valid, sel=0, data=5 → mt_ready=1, lo=5, ov=0.
- mt_valid and mul_valid (write z=0x0000_0002_0000_0003) in the same cycle → mt_ready=0, lo=3, hi=2. The next cycle mt_ready stays 0 (s2_valid). The mt write is accepted the cycle after, then hi=mt_data when sel=1.
- Accumulate accepted at E, reset driven low between E and E+1 → hi=lo=0 and hi_pending=0 immediately. After release, hi stays 0 (pending op lost).
